// File: rtl/sys_bridge_pkg.sv
// Shared constants for sys_bridge: default memory map, timer register
// offsets, CTRL bit layout, MODE encodings and the timer FSM states.
package sys_bridge_pkg;

  // Default memory map; sys_bridge exposes these as overridable parameters.
  localparam logic [31:0] DEF_DM_LIMIT    = 32'h0000_3000;
  localparam logic [31:0] DEF_TIMER0_BASE = 32'h0000_7F00;
  localparam logic [31:0] DEF_TIMER1_BASE = 32'h0000_7F10;

  // Word offsets inside a timer window, taken from address bits [3:2].
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;

  // CTRL layout: bit0 EN, bits[2:1] MODE, bit3 IM; higher bits read as 0.
  localparam int CTRL_W        = 4;
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM_BIT   = 3;

  // MODE encodings; every value other than AUTO behaves as one-shot.
  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_AUTO    = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } timer_state_e;

  // True when addr hits one of the three mapped words of the 16-byte
  // window starting at base (offset 0xC is unmapped).
  function automatic logic in_timer_window(input logic [31:0] addr,
                                           input logic [31:0] base);
    return (((addr ^ base) & 32'hFFFF_FFF0) == 32'h0) && (addr[3:2] != 2'b11);
  endfunction

endpackage

// File: rtl/sys_bridge_timer_counter.sv
// timer_counter: memory-mapped countdown timer with CTRL/PRESET/COUNT
// registers, one-shot and auto-reload modes, and a maskable interrupt.
module timer_counter
  import sys_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  timer_state_e      state_q, state_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [31:0]       preset_q, preset_d;
  logic [31:0]       count_q, count_d;
  logic              flag_q, flag_d;

  logic       en;
  logic [1:0] mode;
  logic       im;

  assign en   = ctrl_q[CTRL_EN_BIT];
  assign mode = ctrl_q[CTRL_MODE_MSB:CTRL_MODE_LSB];
  assign im   = ctrl_q[CTRL_IM_BIT];

  // State and register file update with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    if (reset) begin
      state_q  <= ST_IDLE;
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
    end
  end

  // Next-state: FSM sequencing first, then CPU writes override it.
  always_comb begin
    // NOTE: every variable gets a hold value up front so no path through the
    // case/if tree leaves one unassigned, which would infer a latch.
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    flag_d   = flag_q;

    unique case (state_q)
      ST_IDLE: if (en) state_d = ST_LOAD;
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d = '0;
          flag_d  = 1'b1;
          state_d = ST_INT;
        end
      end
      ST_INT: begin
        if (mode == MODE_AUTO) begin
          flag_d  = 1'b0;
          state_d = ST_LOAD;
        end else begin
          ctrl_d[CTRL_EN_BIT] = 1'b0;
          state_d             = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A CPU write lands after the FSM so it wins any same-cycle conflict;
    // any CTRL write acknowledges a pending interrupt.
    if (we) begin
      unique case (addr)
        REG_CTRL: begin
          ctrl_d = wdata[CTRL_W-1:0];
          flag_d = 1'b0;
        end
        REG_PRESET: preset_d = wdata;
        default: ;
      endcase
    end
  end

  // Zero-latency register read.
  always_comb begin
    rdata = '0;
    unique case (addr)
      REG_CTRL:   rdata = {{(32-CTRL_W){1'b0}}, ctrl_q};
      REG_PRESET: rdata = preset_q;
      REG_COUNT:  rdata = count_q;
      default:    rdata = '0;
    endcase
  end

  assign irq = im & flag_q;

endmodule

// File: rtl/sys_bridge.sv
// sys_bridge: decodes CPU MEM-stage accesses to data memory, timer 0 or
// timer 1, muxes read data, and assembles the hardware interrupt vector.
// Optional macro SYS_BRIDGE_TIMER1_EN instantiates timer 1; without it the
// timer 1 window reads 0, ignores writes and HWInt[1] is 0.
module sys_bridge
  import sys_bridge_pkg::*;
#(
  parameter logic [31:0] DM_LIMIT    = DEF_DM_LIMIT,
  parameter logic [31:0] TIMER0_BASE = DEF_TIMER0_BASE,
  parameter logic [31:0] TIMER1_BASE = DEF_TIMER1_BASE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] BrPC,
  input  logic [31:0] BrAddr,
  input  logic [31:0] BrWData,
  input  logic [3:0]  BrWE,
  output logic [31:0] BrRData,
  output logic [31:0] DM_PC,
  output logic [31:0] DM_Addr,
  output logic [31:0] DM_WData,
  output logic [3:0]  DM_WE,
  input  logic [31:0] DM_RData,
  input  logic [3:0]  HWIntExt,
  output logic [5:0]  HWInt
);

  logic        dm_sel;
  logic        t0_sel;
  logic        t1_sel;
  logic        full_word;
  logic [31:0] t0_rdata;
  logic [31:0] t1_rdata;
  logic        irq0;
  logic        irq1;

  assign dm_sel    = BrAddr < DM_LIMIT;
  assign t0_sel    = in_timer_window(BrAddr, TIMER0_BASE);
  assign full_word = BrWE == 4'b1111;

  assign DM_PC    = BrPC;
  assign DM_Addr  = BrAddr;
  assign DM_WData = BrWData;
  assign DM_WE    = dm_sel ? BrWE : 4'b0000;

  timer_counter u_timer0 (
    .clk   (clk),
    .reset (reset),
    .we    (t0_sel & full_word),
    .addr  (BrAddr[3:2]),
    .wdata (BrWData),
    .rdata (t0_rdata),
    .irq   (irq0)
  );

`ifdef SYS_BRIDGE_TIMER1_EN
  assign t1_sel = in_timer_window(BrAddr, TIMER1_BASE);

  timer_counter u_timer1 (
    .clk   (clk),
    .reset (reset),
    .we    (t1_sel & full_word),
    .addr  (BrAddr[3:2]),
    .wdata (BrWData),
    .rdata (t1_rdata),
    .irq   (irq1)
  );
`else
  assign t1_sel   = 1'b0;
  assign t1_rdata = '0;
  assign irq1     = 1'b0;
`endif

  // Read-data select for the current MEM-stage address.
  always_comb begin
    BrRData = '0;
    if (dm_sel)      BrRData = DM_RData;
    else if (t0_sel) BrRData = t0_rdata;
    else if (t1_sel) BrRData = t1_rdata;
  end

  assign HWInt = {HWIntExt, irq1, irq0};

endmodule

// File: tb/tb_sys_bridge.sv
// Self-checking bench for sys_bridge: directed decode table, hand-written
// timer sequences, then randomized traffic against a behavioural model.
module tb_sys_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] BrPC, BrAddr, BrWData, BrRData;
  logic [3:0]  BrWE, DM_WE, HWIntExt;
  logic [31:0] DM_PC, DM_Addr, DM_WData, DM_RData;
  logic [5:0]  HWInt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sys_bridge dut (
    .clk      (clk),
    .reset    (reset),
    .BrPC     (BrPC),
    .BrAddr   (BrAddr),
    .BrWData  (BrWData),
    .BrWE     (BrWE),
    .BrRData  (BrRData),
    .DM_PC    (DM_PC),
    .DM_Addr  (DM_Addr),
    .DM_WData (DM_WData),
    .DM_WE    (DM_WE),
    .DM_RData (DM_RData),
    .HWIntExt (HWIntExt),
    .HWInt    (HWInt)
  );

  localparam logic [31:0] T0 = 32'h0000_7F00;
  localparam logic [31:0] T1 = 32'h0000_7F10;
`ifdef SYS_BRIDGE_TIMER1_EN
  localparam int NT = 2;
`else
  localparam int NT = 1;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd);
    BrAddr  = a;
    BrWE    = we;
    BrWData = wd;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus(32'h0, 4'h0, 32'h0);
    step();
    step();
    reset = 1'b0;
  endtask

  // ---------------- behavioural timer model ----------------
  // The timer is described by what it is doing this cycle: waiting to be
  // enabled, about to load, counting down, or signalling expiry.
  typedef struct {
    bit        en;
    bit [1:0]  mode;
    bit        im;
    bit [31:0] preset;
    bit [31:0] count;
    bit        flag;
    int        doing;   // 0 waiting, 1 loading, 2 counting, 3 expired
  } tmod_t;

  tmod_t tm[2];

  function automatic tmod_t tmod_clear();
    tmod_t t;
    t.en = 0; t.mode = 0; t.im = 0; t.preset = 0; t.count = 0; t.flag = 0; t.doing = 0;
    return t;
  endfunction

  function automatic tmod_t tmod_next(tmod_t t, bit wr, bit [1:0] off, bit [31:0] wd);
    tmod_t n = t;
    if (t.doing == 0) begin
      if (t.en) n.doing = 1;
    end else if (t.doing == 1) begin
      n.count = t.preset;
      n.doing = 2;
    end else if (t.doing == 2) begin
      if (!t.en) n.doing = 0;
      else if (t.count > 1) n.count = t.count - 1;
      else begin
        n.count = 0;
        n.flag  = 1;
        n.doing = 3;
      end
    end else begin
      if (t.mode == 2'b01) begin
        n.flag  = 0;
        n.doing = 1;
      end else begin
        n.en    = 0;
        n.doing = 0;
      end
    end
    if (wr && off == 2'd0) begin
      n.en   = wd[0];
      n.mode = wd[2:1];
      n.im   = wd[3];
      n.flag = 0;
    end else if (wr && off == 2'd1) begin
      n.preset = wd;
    end
    return n;
  endfunction

  function automatic int timer_hit(logic [31:0] a);
    for (int i = 0; i < NT; i++) begin
      logic [31:0] base = (i == 0) ? T0 : T1;
      if (a[31:4] == base[31:4]) return i;
    end
    return -1;
  endfunction

  function automatic logic [31:0] model_read(logic [31:0] a, logic [31:0] dmr);
    int ti;
    if (a < 32'h3000) return dmr;
    ti = timer_hit(a);
    if (ti < 0) return 32'h0;
    case (a[3:2])
      2'd0: return {28'h0, tm[ti].im, tm[ti].mode, tm[ti].en};
      2'd1: return tm[ti].preset;
      2'd2: return tm[ti].count;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [5:0] model_hw(logic [3:0] ext);
    return {ext, tm[1].im & tm[1].flag, tm[0].im & tm[0].flag};
  endfunction

  // ---------------- directed decode table ----------------
  typedef struct {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic [31:0] dmr;
    logic [3:0]  ext;
    logic [3:0]  exp_dm_we;
    logic [31:0] exp_rdata;
    logic [5:0]  exp_hw;
  } vec_t;

  vec_t vecs[9];
  logic [31:0] alist[10];

  initial begin
    reset    = 1'b1;
    BrPC     = 32'h0;
    BrAddr   = 32'h0;
    BrWData  = 32'h0;
    BrWE     = 4'h0;
    DM_RData = 32'h0;
    HWIntExt = 4'h0;

    vecs[0] = '{32'h0000_0010, 4'b0011, 32'h1111_2222, 32'hAAAA_5555, 4'h0, 4'b0011, 32'hAAAA_5555, 6'b000000};
    vecs[1] = '{32'h0000_7F04, 4'b0000, 32'h0,         32'h1234_5678, 4'h5, 4'b0000, 32'h0,         6'b010100};
    vecs[2] = '{32'h0000_5000, 4'b1111, 32'hDEAD_BEEF, 32'h0000_1111, 4'hF, 4'b0000, 32'h0,         6'b111100};
    vecs[3] = '{32'h0000_2FFC, 4'b1111, 32'h0BAD_F00D, 32'hCAFE_F00D, 4'h0, 4'b1111, 32'hCAFE_F00D, 6'b000000};
    vecs[4] = '{32'h0000_3000, 4'b1111, 32'h0000_0077, 32'h0000_0077, 4'h0, 4'b0000, 32'h0,         6'b000000};
    vecs[5] = '{32'h0000_7F00, 4'b0001, 32'h0000_0009, 32'h0,         4'h0, 4'b0000, 32'h0,         6'b000000};
    vecs[6] = '{32'h0000_7F00, 4'b0000, 32'h0,         32'h0,         4'h0, 4'b0000, 32'h0,         6'b000000};
    vecs[7] = '{32'h0000_7F10, 4'b1111, 32'h0000_000F, 32'h0,         4'h3, 4'b0000, 32'h0,         6'b001100};
`ifdef SYS_BRIDGE_TIMER1_EN
    vecs[8] = '{32'h0000_7F10, 4'b0000, 32'h0,         32'h0,         4'h0, 4'b0000, 32'h0000_000F, 6'b000000};
`else
    vecs[8] = '{32'h0000_7F10, 4'b0000, 32'h0,         32'h0,         4'h0, 4'b0000, 32'h0,         6'b000000};
`endif

    alist = '{32'h7F00, 32'h7F04, 32'h7F08, 32'h7F0C, 32'h7F10, 32'h7F14, 32'h7F18,
              32'h0100, 32'h2FFC, 32'h5000};

    // Reset state
    step();
    step();
    check("reset_hwint", {26'h0, HWInt}, 32'h0);
    reset = 1'b0;
    bus(T0 + 32'h8, 4'h0, 32'h0);
    check("reset_count0", BrRData, 32'h0);

    // Decode/routing table
    for (int i = 0; i < 9; i++) begin
      BrPC     = $urandom;
      DM_RData = vecs[i].dmr;
      HWIntExt = vecs[i].ext;
      bus(vecs[i].addr, vecs[i].we, vecs[i].wdata);
      check($sformatf("vec%0d_dm_we", i), {28'h0, DM_WE}, {28'h0, vecs[i].exp_dm_we});
      check($sformatf("vec%0d_rdata", i), BrRData, vecs[i].exp_rdata);
      check($sformatf("vec%0d_hwint", i), {26'h0, HWInt}, {26'h0, vecs[i].exp_hw});
      check($sformatf("vec%0d_dm_addr", i), DM_Addr, vecs[i].addr);
      check($sformatf("vec%0d_dm_pc", i), DM_PC, BrPC);
      check($sformatf("vec%0d_dm_wdata", i), DM_WData, vecs[i].wdata);
      step();
    end
    DM_RData = 32'h0;
    HWIntExt = 4'h0;

    // One-shot: PRESET=3, CTRL=9
    do_reset();
    bus(T0 + 32'h4, 4'hF, 32'd3); step();
    bus(T0, 4'hF, 32'h9);         step();       // CTRL now set, waiting
    bus(T0 + 32'h8, 4'h0, 32'h0); step();       // loading
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("oneshot_count_%0d", k), BrRData, 32'd3 - k);
      check($sformatf("oneshot_irq_%0d", k), {31'h0, HWInt[0]}, (k == 3) ? 32'd1 : 32'd0);
    end
    step();
    bus(T0, 4'h0, 32'h0);
    check("oneshot_ctrl_en_cleared", BrRData, 32'h8);
    check("oneshot_irq_held", {31'h0, HWInt[0]}, 32'd1);
    step(); step();
    check("oneshot_irq_still_held", {31'h0, HWInt[0]}, 32'd1);
    bus(T0, 4'hF, 32'h0); step();
    bus(T0 + 32'h8, 4'h0, 32'h0);
    check("oneshot_irq_cleared", {31'h0, HWInt[0]}, 32'd0);
    check("oneshot_count_rest", BrRData, 32'h0);

    // Auto-reload: PRESET=2, CTRL=0xB -> 1-cycle pulse every 4 cycles
    do_reset();
    bus(T0 + 32'h4, 4'hF, 32'd2); step();
    bus(T0, 4'hF, 32'hB);         step();
    bus(32'h0, 4'h0, 32'h0);
    for (int k = 1; k <= 14; k++) begin
      step();
      check($sformatf("auto_irq_k%0d", k), {31'h0, HWInt[0]},
            (k >= 4 && ((k - 4) % 4) == 0) ? 32'd1 : 32'd0);
    end

    // Partial write to CTRL is dropped
    do_reset();
    bus(T0, 4'b0001, 32'h9); step();
    bus(T0, 4'b0111, 32'h9); step();
    bus(T0, 4'h0, 32'h0);
    check("partial_ctrl", BrRData, 32'h0);
    step(); step();
    bus(T0 + 32'h8, 4'h0, 32'h0);
    check("partial_no_count", BrRData, 32'h0);
    check("partial_no_irq", {26'h0, HWInt}, 32'h0);

    // PRESET=0: expiry right after the load
    do_reset();
    bus(T0, 4'hF, 32'h9); step();
    bus(32'h0, 4'h0, 32'h0);
    step();                                      // loading
    step();
    check("preset0_not_yet", {31'h0, HWInt[0]}, 32'd0);
    step();
    check("preset0_irq", {31'h0, HWInt[0]}, 32'd1);

    // IM=0: counting proceeds, no interrupt
    do_reset();
    bus(T0 + 32'h4, 4'hF, 32'd2); step();
    bus(T0, 4'hF, 32'h1);         step();
    bus(T0 + 32'h8, 4'h0, 32'h0);
    step(); step();
    check("im0_count2", BrRData, 32'd2);
    step();
    check("im0_count1", BrRData, 32'd1);
    step();
    check("im0_count0", BrRData, 32'd0);
    check("im0_no_irq", {31'h0, HWInt[0]}, 32'd0);
    step();
    bus(T0, 4'h0, 32'h0);
    check("im0_en_cleared", BrRData, 32'h0);

    // Reset while counting with COUNT=5
    do_reset();
    HWIntExt = 4'hA;
    bus(T0 + 32'h4, 4'hF, 32'd9); step();
    bus(T0, 4'hF, 32'h9);         step();
    bus(T0 + 32'h8, 4'h0, 32'h0);
    for (int k = 0; k < 6; k++) step();
    check("midreset_count5", BrRData, 32'd5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("midreset_count0", BrRData, 32'h0);
    check("midreset_hwint", {26'h0, HWInt}, {26'h0, 4'hA, 2'b00});
    step(); step(); step();
    check("midreset_stays_idle", BrRData, 32'h0);
    bus(T0, 4'h0, 32'h0);
    check("midreset_ctrl0", BrRData, 32'h0);

    // Timer 1 window
    do_reset();
    bus(T1, 4'hF, 32'hF); step();
    bus(T1, 4'h0, 32'h0);
`ifdef SYS_BRIDGE_TIMER1_EN
    check("t1_ctrl_readback", BrRData, 32'hF);
`else
    check("t1_absent_read", BrRData, 32'h0);
    for (int k = 0; k < 4; k++) step();
    check("t1_absent_irq", {31'h0, HWInt[1]}, 32'd0);
`endif

    // Randomized traffic against the model
    do_reset();
    HWIntExt = 4'h0;
    for (int i = 0; i < NT; i++) tm[i] = tmod_clear();
    tm[1] = tmod_clear();
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic [31:0] a, wd;
      logic [3:0]  we;
      int          ti;
      a  = alist[$urandom_range(0, 9)];
      we = 4'h0;
      wd = $urandom;
      if ($urandom_range(0, 99) < 30) begin
        we = ($urandom_range(0, 9) < 8) ? 4'hF : 4'($urandom_range(0, 15));
        if (a[3:2] == 2'd0) wd = {$urandom, 4'($urandom_range(0, 15))} >> 0;
        if (a[3:2] == 2'd0) wd[0] = ($urandom_range(0, 3) != 0);
        if (a[3:2] == 2'd1) wd = $urandom_range(0, 6);
      end
      BrPC     = $urandom;
      DM_RData = $urandom;
      HWIntExt = 4'($urandom_range(0, 15));
      bus(a, we, wd);
      check("rnd_rdata", BrRData, model_read(a, DM_RData));
      check("rnd_hwint", {26'h0, HWInt}, {26'h0, model_hw(HWIntExt)});
      check("rnd_dm_we", {28'h0, DM_WE}, {28'h0, (a < 32'h3000) ? we : 4'h0});
      ti = timer_hit(a);
      for (int i = 0; i < NT; i++)
        tm[i] = tmod_next(tm[i], (ti == i) && (we == 4'hF), a[3:2], wd);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
